note_row_fetch: RTL and testbench
=================================

# note_row_fetch

Consumer end of the map-offset stream produced by the game's offset generator. On each beat it pulses `map` to advance the generator, turns the returned offset into a note-ROM address, reads one note byte, and queues the decoded note row in a small FIFO for the lane renderer. Sits between the offset generator, the song note ROM and the renderer in the game datapath.

## Interface
- `BEAT_DIV`, default 25_000_000: clocks per beat. Legal range is 4 or more.
- `ADDR_W`, default 10: note-ROM address width.
- `FIFO_DEPTH`, default 4: note-row FIFO depth. Must be a power of 2.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  game running; beat timer runs only while high.
- `map`  out  1  advance strobe to the generator; high for exactly one cycle per fetch.
- `gen_en`  in  1  generator's data-valid flag.
- `gen_data`  in  8  generator offset, in the sequence 4, 8, 12, 16, 0, 4, …
- `song_base`  in  ADDR_W  base address of the current song segment.
- `rom_rd`  out  1  ROM read strobe.
- `rom_addr`  out  ADDR_W  ROM read address.
- `rom_q`  in  8  ROM data; valid the cycle after `rom_rd`.
- `row_valid`  out  1  FIFO not empty.
- `row_ready`  in  1  renderer accepts the head row.
- `row_lanes`  out  4  head row lane hits, taken from `rom_q[3:0]`.
- `row_hold`  out  4  head row hold length, taken from `rom_q[7:4]`.
- `seg_done`  out  1  one-cycle pulse when a row fetched at offset 0 is pushed (segment wrapped).
- `beat_miss`  out  8  saturating count of beats lost to overrun.

## Operation
- **Beat timer**
  - `beat_cnt` counts 0 to BEAT_DIV-1 while `enable` is high.
  - At terminal count, `beat_cnt` returns to 0 and `beat_pending` is set.
  - When `enable` is low, `beat_cnt` is forced to 0 and `beat_pending` is cleared.
- **Overrun**
  - A terminal count while `beat_pending` is already 1, and not being cleared that cycle, increments `beat_miss`.
  - `beat_miss` saturates at 255.
- **FSM states**
  - IDLE → ADVANCE when `beat_pending` & `gen_en` & FIFO not full; `beat_pending` clears on this transition.
  - ADVANCE: `map`=1. Next state is READ.
  - READ: `rom_rd`=1 and `rom_addr` = `song_base` + zero-extended `gen_data`, modulo 2^ADDR_W. Next state is CAPTURE.
  - CAPTURE: push `rom_q` into the FIFO. Pulse `seg_done` if the offset used in READ was 0. Next state is IDLE.
- **Output drive**
  - `map` and `rom_rd` are Moore outputs of ADVANCE and READ.
  - `rom_addr` is 0 outside READ.
- **Mid-transaction inputs**
  - `enable` falling mid-transaction does not abort it; the FSM completes to IDLE.
  - `gen_en` is checked only in IDLE.
- **FIFO**
  - First-word fall-through; the head row is presented on `row_lanes`/`row_hold`.
  - Pop on `row_valid` & `row_ready`.
  - Simultaneous push and pop leaves the occupancy unchanged.
  - A push never occurs when full; the IDLE guard guarantees room, since only one fetch is in flight.
  - While empty, `row_lanes`/`row_hold` are don't-care; the bench masks them with `row_valid`.
- **Reset** (any cycle, including mid-transaction)
  - FSM returns to IDLE, the FIFO empties, and both counters clear.
  - All outputs go to 0: `map`, `rom_rd`, `rom_addr`, `row_valid`, `row_lanes`, `row_hold`, `seg_done`, `beat_miss`.

## Timing
- Terminal count at cycle T gives `beat_pending` at T+1.
- With IDLE and the other guards true at T+1, `map`=1 at T+2.
- The generator updates on the edge ending the `map` cycle, so READ (T+3) uses the new offset.
- CAPTURE is at T+4; `row_valid` rises at T+5 if the FIFO was empty. `seg_done` is high during T+4 only.
- Minimum spacing between `map` pulses is 4 cycles, hence BEAT_DIV ≥ 4.
- When the FIFO is full, the fetch stalls in IDLE with `beat_pending` held; subsequent beats count toward `beat_miss`.

## Test plan
- **Basic fetch sequence.** Conditions: BEAT_DIV=8, `enable`=1, `gen_en`=1, `song_base`=0x100, `row_ready`=1. Expected: `map` pulses every 8 cycles; `rom_addr` sequence is 0x104, 0x108, 0x10C, 0x110, 0x100; `seg_done` pulses only on the 0x100 fetch; `row_lanes`/`row_hold` match the ROM nibbles.
- **Backpressure and overrun.** Conditions: `row_ready`=0. Expected: 4 rows are queued, then `map` stops; each further beat increments `beat_miss`. Raising `row_ready` for 1 cycle pops one row and resumes exactly one fetch.
- **Saturation.** Conditions: hold the full-FIFO case for 300 beats. Expected: `beat_miss` stays at 255.
- **Address wrap.** Conditions: ADDR_W=10, `song_base`=0x3FE, `gen_data`=4. Expected: `rom_addr`=0x002.
- **Mid-read disruptions.** Conditions: deassert `enable` during READ. Expected: CAPTURE still pushes the row, then no further `map`.
  - Variant: assert `resetn`=0 during CAPTURE. Expected: no push occurs and all outputs read 0 immediately.
- **Generator not ready.** Conditions: `gen_en`=0 with a beat pending. Expected: `map` stays 0 until `gen_en`=1, then `map` fires on the next cycle.

Source files
------------

// File: rtl/note_row_fetch_if.sv
// Signal bundle between note_row_fetch and its neighbours: offset generator,
// note ROM and lane renderer. The fetch block is the slave side.
interface note_row_fetch_if #(
    parameter int ADDR_W = 10
);
    logic              enable;
    logic              map;
    logic              gen_en;
    logic [7:0]        gen_data;
    logic [ADDR_W-1:0] song_base;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_q;
    logic              row_valid;
    logic              row_ready;
    logic [3:0]        row_lanes;
    logic [3:0]        row_hold;
    logic              seg_done;
    logic [7:0]        beat_miss;

    modport slave (
        input  enable, gen_en, gen_data, song_base, rom_q, row_ready,
        output map, rom_rd, rom_addr, row_valid, row_lanes, row_hold,
        seg_done, beat_miss
    );

    modport master (
        output enable, gen_en, gen_data, song_base, rom_q, row_ready,
        input  map, rom_rd, rom_addr, row_valid, row_lanes, row_hold,
        seg_done, beat_miss
    );
endinterface

// File: rtl/note_row_fetch.sv
// Beat-paced fetch of note rows: advance the offset generator, read one ROM
// byte at song_base + offset, and queue it in a small fall-through FIFO.
module note_row_fetch #(
    parameter int BEAT_DIV   = 25_000_000,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            resetn,
    note_row_fetch_if.slave bus
);
    localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(BEAT_DIV - 1);
    localparam logic [AW:0]      FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADVANCE,
        S_READ,
        S_CAPTURE
    } state_t;

    state_t            state_reg;
    logic              map_reg;
    logic              rom_rd_reg;
    logic              seg_done_reg;

    logic [CNT_W-1:0]  beat_cnt_reg;
    logic              beat_pending_reg;
    logic [7:0]        beat_miss_reg;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;

    logic              beat_tc;
    logic              fifo_full;
    logic              fetch_start;
    logic              push;
    logic              pop;
    logic              row_valid;
    logic [7:0]        head_row;
    logic [ADDR_W-1:0] rom_addr_next;

    assign beat_tc     = bus.enable && (beat_cnt_reg == CNT_LAST);
    assign fifo_full   = (count_reg == FIFO_FULL_CNT);
    assign fetch_start = (state_reg == S_IDLE) && beat_pending_reg && bus.gen_en && !fifo_full;
    assign push        = (state_reg == S_CAPTURE);
    assign row_valid   = (count_reg != '0);
    assign pop         = row_valid && bus.row_ready;
    assign head_row    = fifo_mem[rd_ptr_reg];

    // The generator steps on the edge that ends the map cycle, so the address
    // is formed from the live offset while in READ rather than registered.
    always_comb begin
        rom_addr_next = '0;
        if (state_reg == S_READ) begin
            rom_addr_next = bus.song_base + ADDR_W'(bus.gen_data);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt_reg     <= '0;
            beat_pending_reg <= 1'b0;
            beat_miss_reg    <= '0;
        end else if (!bus.enable) begin
            beat_cnt_reg     <= '0;
            beat_pending_reg <= 1'b0;
        end else begin
            beat_cnt_reg <= beat_tc ? '0 : beat_cnt_reg + 1'b1;
            // A fresh beat wins over the one being consumed this same cycle.
            if (beat_tc) begin
                beat_pending_reg <= 1'b1;
            end else if (fetch_start) begin
                beat_pending_reg <= 1'b0;
            end
            if (beat_tc && beat_pending_reg && !fetch_start && (beat_miss_reg != 8'd255)) begin
                beat_miss_reg <= beat_miss_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            map_reg      <= 1'b0;
            rom_rd_reg   <= 1'b0;
            seg_done_reg <= 1'b0;
        end else begin
            map_reg      <= 1'b0;
            rom_rd_reg   <= 1'b0;
            seg_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (fetch_start) begin
                        state_reg <= S_ADVANCE;
                        map_reg   <= 1'b1;
                    end
                end
                S_ADVANCE: begin
                    state_reg  <= S_READ;
                    rom_rd_reg <= 1'b1;
                end
                S_READ: begin
                    state_reg    <= S_CAPTURE;
                    seg_done_reg <= (bus.gen_data == 8'd0);
                end
                S_CAPTURE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Row storage carries no reset; outputs are masked by occupancy instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= bus.rom_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign bus.map       = map_reg;
    assign bus.rom_rd    = rom_rd_reg;
    assign bus.rom_addr  = rom_addr_next;
    assign bus.seg_done  = seg_done_reg;
    assign bus.beat_miss = beat_miss_reg;
    assign bus.row_valid = row_valid;
    assign bus.row_lanes = row_valid ? head_row[3:0] : 4'h0;
    assign bus.row_hold  = row_valid ? head_row[7:4] : 4'h0;
endmodule

// File: tb/tb_note_row_fetch.sv
// Directed bench for note_row_fetch with a behavioural offset generator and
// a note ROM whose byte at address a is a[7:0] ^ 8'h5A.
module tb_note_row_fetch;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;
    int   cyc;

    int         map_q[$];
    int         rdc_q[$];
    int         segc_q[$];
    int         popc_q[$];
    logic [9:0] rd_q[$];
    logic [7:0] row_q[$];

    note_row_fetch_if #(.ADDR_W(10)) bus ();

    note_row_fetch #(
        .BEAT_DIV   (8),
        .ADDR_W     (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offset generator: 0 after reset, then 4, 8, 12, 16, 0, ... per map pulse.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.gen_data <= 8'd0;
        end else if (bus.map) begin
            bus.gen_data <= (bus.gen_data == 8'd16) ? 8'd0 : bus.gen_data + 8'd4;
        end
    end

    always @(posedge clk) begin
        if (bus.rom_rd) begin
            bus.rom_q <= bus.rom_addr[7:0] ^ 8'h5A;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bus.map) map_q.push_back(cyc);
        if (bus.rom_rd) begin
            rd_q.push_back(bus.rom_addr);
            rdc_q.push_back(cyc);
        end
        if (bus.seg_done) segc_q.push_back(cyc);
        if (bus.row_valid && bus.row_ready) begin
            row_q.push_back({bus.row_hold, bus.row_lanes});
            popc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        map_q.delete();
        rdc_q.delete();
        segc_q.delete();
        popc_q.delete();
        rd_q.delete();
        row_q.delete();
    endtask

    task automatic wait_reads(input int n, input string tag);
        for (int i = 0; i < 200 && rd_q.size() < n; i++) step();
        check(tag, rd_q.size(), n);
    endtask

    task automatic wait_rows(input int n, input string tag);
        for (int i = 0; i < 200 && row_q.size() < n; i++) step();
        check(tag, row_q.size(), n);
    endtask

    task automatic wait_rom_rd(input string tag);
        for (int i = 0; i < 50 && !bus.rom_rd; i++) step();
        check(tag, bus.rom_rd, 1);
    endtask

    function automatic logic [31:0] outs();
        return {2'b00, bus.map, bus.rom_rd, bus.rom_addr, bus.row_valid,
                bus.row_lanes, bus.row_hold, bus.seg_done, bus.beat_miss};
    endfunction

    logic [9:0] exp_addr [5];
    logic [7:0] exp_row  [5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        exp_addr = '{10'h104, 10'h108, 10'h10C, 10'h110, 10'h100};
        exp_row  = '{8'h5E, 8'h52, 8'h56, 8'h4A, 8'h5A};

        resetn        = 1'b0;
        bus.enable    = 1'b0;
        bus.gen_en    = 1'b0;
        bus.song_base = 10'h000;
        bus.row_ready = 1'b0;
        repeat (3) step();
        check("reset_outputs", outs(), 32'h0);

        // Basic fetch sequence
        resetn        = 1'b1;
        bus.gen_en    = 1'b1;
        bus.song_base = 10'h100;
        bus.row_ready = 1'b1;
        clear_q();
        bus.enable    = 1'b1;
        wait_reads(5, "basic_reads");
        wait_rows(5, "basic_rows");
        for (int i = 0; i < 5; i++) begin
            if (i < rd_q.size())  check($sformatf("basic_addr%0d", i), rd_q[i], exp_addr[i]);
            if (i < row_q.size()) check($sformatf("basic_row%0d", i), row_q[i], exp_row[i]);
            if (i > 0 && i < map_q.size())
                check($sformatf("basic_map_gap%0d", i), map_q[i] - map_q[i-1], 8);
        end
        if (map_q.size() > 0 && rdc_q.size() > 0) check("map_to_read", rdc_q[0] - map_q[0], 1);
        if (rdc_q.size() > 0 && popc_q.size() > 0) check("read_to_row", popc_q[0] - rdc_q[0], 2);
        check("seg_done_count", segc_q.size(), 1);
        if (segc_q.size() > 0 && rdc_q.size() > 4) check("seg_done_at_0x100", segc_q[0] - rdc_q[4], 1);
        check("basic_no_miss", bus.beat_miss, 0);
        bus.enable = 1'b0;
        repeat (10) step();

        // Backpressure and overrun
        clear_q();
        bus.row_ready = 1'b0;
        bus.enable    = 1'b1;
        wait_reads(4, "bp_reads");
        repeat (24) step();
        check("bp_map_stops", map_q.size(), 4);
        check("bp_row_valid", bus.row_valid, 1);
        check("bp_head0", {bus.row_hold, bus.row_lanes}, 8'h5E);
        check("bp_miss_a", bus.beat_miss, 2);
        repeat (40) step();
        check("bp_miss_b", bus.beat_miss, 7);
        check("bp_no_map", map_q.size(), 4);
        bus.row_ready = 1'b1;
        step();
        bus.row_ready = 1'b0;
        repeat (6) step();
        check("bp_one_fetch", map_q.size(), 5);
        check("bp_head1", {bus.row_hold, bus.row_lanes}, 8'h52);
        repeat (40) step();
        check("bp_only_one", map_q.size(), 5);
        if (rd_q.size() > 4) check("bp_resume_addr", rd_q[4], 10'h100);

        // Saturation
        repeat (2400) step();
        check("sat_miss", bus.beat_miss, 255);
        bus.enable    = 1'b0;
        bus.row_ready = 1'b1;
        repeat (10) step();
        check("drain_empty", bus.row_valid, 0);
        check("sat_hold", bus.beat_miss, 255);
        resetn = 1'b0;
        #1;
        check("reset_clears_miss", bus.beat_miss, 0);
        step();
        step();
        resetn = 1'b1;

        // Address wrap, then enable dropped during READ
        clear_q();
        bus.song_base = 10'h3FE;
        bus.enable    = 1'b1;
        wait_reads(1, "wrap_reads");
        if (rd_q.size() > 0) check("wrap_addr", rd_q[0], 10'h002);
        wait_rows(1, "wrap_rows");
        if (row_q.size() > 0) check("wrap_row", row_q[0], 8'h58);
        wait_rom_rd("midread_seen");
        bus.enable = 1'b0;
        repeat (4) step();
        check("midread_rows", row_q.size(), 2);
        if (row_q.size() > 1) check("midread_row", row_q[1], 8'h5C);
        if (rd_q.size() > 1) check("midread_addr", rd_q[1], 10'h006);
        repeat (40) step();
        check("midread_no_map", map_q.size(), 2);

        // Reset during CAPTURE
        bus.row_ready = 1'b0;
        bus.enable    = 1'b1;
        wait_rom_rd("cap_rd_seen");
        step();
        check("cap_pre_empty", bus.row_valid, 0);
        resetn = 1'b0;
        #1;
        check("cap_rst_outputs", outs(), 32'h0);
        bus.enable = 1'b0;
        step();
        step();
        resetn = 1'b1;
        repeat (3) step();
        check("cap_no_push", bus.row_valid, 0);

        // Generator not ready
        clear_q();
        bus.song_base = 10'h100;
        bus.gen_en    = 1'b0;
        bus.row_ready = 1'b1;
        bus.enable    = 1'b1;
        repeat (20) step();
        check("gen_wait_no_map", map_q.size(), 0);
        bus.gen_en = 1'b1;
        step();
        check("gen_map_next", bus.map, 1);
        repeat (4) step();
        check("gen_reads", rd_q.size(), 1);
        if (rd_q.size() > 0) check("gen_addr", rd_q[0], 10'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
